// File: rtl/slot_btn_cond_pkg.sv
// rtl/slot_btn_cond_pkg.sv - shared debounce state encoding and default constants
//
// Purpose : common definitions for the start/stop button conditioner.
// Contents: db_state_e   per-channel debounce FSM state (2-bit encoding)
//           DB_CYCLES_DEFAULT  default number of consecutive samples to accept

package slot_btn_cond_pkg;

   localparam int DB_CYCLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } db_state_e;

endpackage

// File: rtl/slot_debounce.sv
// rtl/slot_debounce.sv - one button channel: 2-flop synchronizer plus debounce FSM
//
// Purpose : synchronizes one raw active-low button and debounces it.
// Ports   : clk        system clock, rising edge
//           reset      synchronous, active-high
//           btn_n      raw button, active-low, asynchronous to clk
//           pulse_raw  high in the cycle whose edge accepts a press (next-state view)
//           held       accepted pressed level as of the coming edge (next-state view)
//
// pulse_raw and held are the FSM's next-state decisions; the parent registers them
// so the conditioned outputs change on the same edge the FSM changes state.

module slot_debounce
   import slot_btn_cond_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
)
(
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic pulse_raw,
   output logic held
);

   localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic             s1_q, s2_q;
   logic             s1_d, s2_d;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed;

   // The FSM only ever looks at the second synchronizer stage.
   assign pressed = ~s2_q;

   always_comb begin
      s1_d      = btn_n;
      s2_d      = s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_raw = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pressed) begin
               if (DB_CYCLES == 1) begin
                  // A single sample is enough: accept immediately.
                  state_d   = ST_HELD;
                  cnt_d     = CNT_ZERO;
                  pulse_raw = 1'b1;
               end else begin
                  state_d = ST_DB_PRESS;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end

         ST_DB_PRESS: begin
            if (!pressed) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_HELD;
               cnt_d     = CNT_ZERO;
               pulse_raw = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_HELD: begin
            if (!pressed) begin
               if (DB_CYCLES == 1) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  state_d = ST_DB_RELEASE;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end

         ST_DB_RELEASE: begin
            if (pressed) begin
               // Release bounce: go back to HELD without a new pulse.
               state_d = ST_HELD;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      // While debouncing a release the button still counts as held.
      held = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/slot_btn_cond.sv
// rtl/slot_btn_cond.sv - start/stop pushbutton conditioner feeding slot_top
//
// Purpose : turns the raw active-low start/stop buttons into clean one-cycle
//           press pulses and debounced held levels.
// Ports   : clk          system clock, rising edge
//           reset        synchronous, active-high
//           start_n      raw start button, active-low, asynchronous
//           stop_n       raw stop button, active-low, asynchronous
//           start_pulse  one-cycle pulse per accepted start press
//           stop_pulse   one-cycle pulse per accepted stop press
//           start_held   debounced start level
//           stop_held    debounced stop level

module slot_btn_cond
   import slot_btn_cond_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
)
(
   input  logic clk,
   input  logic reset,
   input  logic start_n,
   input  logic stop_n,
   output logic start_pulse,
   output logic stop_pulse,
   output logic start_held,
   output logic stop_held
);

   logic start_pulse_raw, stop_pulse_raw;
   logic start_held_raw,  stop_held_raw;

   logic start_pulse_q, start_pulse_d;
   logic stop_pulse_q,  stop_pulse_d;
   logic start_held_q,  start_held_d;
   logic stop_held_q,   stop_held_d;

   slot_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (start_n),
      .pulse_raw (start_pulse_raw),
      .held      (start_held_raw)
   );

   slot_debounce #(.DB_CYCLES(DB_CYCLES)) u_stop_db (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (stop_n),
      .pulse_raw (stop_pulse_raw),
      .held      (stop_held_raw)
   );

   always_comb begin
      start_pulse_d = start_pulse_raw;
      // Start wins a same-edge tie; the stop press is still tracked as held
      // but its one acceptance pulse is dropped for good.
      stop_pulse_d  = stop_pulse_raw & ~start_pulse_raw;
      start_held_d  = start_held_raw;
      stop_held_d   = stop_held_raw;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         start_pulse_q <= 1'b0;
         stop_pulse_q  <= 1'b0;
         start_held_q  <= 1'b0;
         stop_held_q   <= 1'b0;
      end else begin
         start_pulse_q <= start_pulse_d;
         stop_pulse_q  <= stop_pulse_d;
         start_held_q  <= start_held_d;
         stop_held_q   <= stop_held_d;
      end
   end

   assign start_pulse = start_pulse_q;
   assign stop_pulse  = stop_pulse_q;
   assign start_held  = start_held_q;
   assign stop_held   = stop_held_q;

endmodule

// File: tb/tb_slot_btn_cond.sv
// tb/tb_slot_btn_cond.sv - self-checking bench for slot_btn_cond

module tb_slot_btn_cond;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic reset;
   logic start_n;
   logic stop_n;
   logic start_pulse, stop_pulse, start_held, stop_held;

   slot_btn_cond #(.DB_CYCLES(DB)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_n     (start_n),
      .stop_n      (stop_n),
      .start_pulse (start_pulse),
      .stop_pulse  (stop_pulse),
      .start_held  (start_held),
      .stop_held   (stop_held)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int failed    = 0;
   int cyc       = 0;

   // Reference model: raw -> two-sample delay -> accepted level that flips only
   // after DB consecutive samples disagreeing with it.
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_lvl[2];
   int m_run[2];
   bit exp_pulse[2];
   bit exp_held [2];

   int n_start_p   = 0;
   int n_stop_p    = 0;
   int start_p_cyc = -1;
   int stop_p_cyc  = -1;
   int n_stop_held = 0;

   task automatic chk(input string tag, input logic got, input logic exp);
      tests_run++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      tests_run++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic a, input logic b, input logic rst);
      bit raw[2];
      bit acc[2];
      bit v;
      start_n = a;
      stop_n  = b;
      reset   = rst;
      raw[0]  = a;
      raw[1]  = b;
      @(posedge clk);
      cyc++;
      for (int ch = 0; ch < 2; ch++) begin
         acc[ch] = 1'b0;
         if (rst) begin
            m_s1[ch]  = 1'b1;
            m_s2[ch]  = 1'b1;
            m_lvl[ch] = 1'b0;
            m_run[ch] = 0;
         end else begin
            v = ~m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = raw[ch];
            if (v != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == DB) begin
                  m_lvl[ch] = v;
                  m_run[ch] = 0;
                  acc[ch]   = v;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
         exp_held[ch] = m_lvl[ch];
      end
      exp_pulse[0] = acc[0];
      exp_pulse[1] = acc[1] & ~acc[0];
      #1;
      chk("start_pulse", start_pulse, exp_pulse[0]);
      chk("stop_pulse",  stop_pulse,  exp_pulse[1]);
      chk("start_held",  start_held,  exp_held[0]);
      chk("stop_held",   stop_held,   exp_held[1]);
      if (start_pulse === 1'b1) begin n_start_p++; start_p_cyc = cyc; end
      if (stop_pulse === 1'b1)  begin n_stop_p++;  stop_p_cyc  = cyc; end
      if (stop_held === 1'b1)   n_stop_held++;
   endtask

   initial begin
      int n0, s0, h0, edge_n, rlen;
      bit ra, rb, rr;

      // 1: reset with buttons released, then idle
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
      chk("reset_start_pulse", start_pulse, 1'b0);
      chk("reset_stop_held",   stop_held,   1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
      chk_int("idle_start_pulses", n_start_p, 0);
      chk_int("idle_stop_pulses",  n_stop_p,  0);

      // 2: clean start press of 7 cycles
      n0 = n_start_p;
      edge_n = cyc + 1;
      for (int i = 0; i < 7; i++)  step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      chk_int("press_pulse_count", n_start_p - n0, 1);
      chk_int("press_latency", start_p_cyc - edge_n, DB + 1);
      chk("press_released", start_held, 1'b0);

      // 3: stop glitches shorter than DB samples
      s0 = n_stop_p;
      h0 = n_stop_held;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      chk_int("glitch_stop_pulses", n_stop_p - s0, 0);
      chk_int("glitch_stop_held",   n_stop_held - h0, 0);

      // 4: start and stop pressed on the same edge
      n0 = n_start_p;
      s0 = n_stop_p;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
      chk("both_start_held", start_held, 1'b1);
      chk("both_stop_held",  stop_held,  1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      chk_int("both_start_pulses", n_start_p - n0, 1);
      chk_int("both_stop_pulses",  n_stop_p - s0, 0);

      // 5: release bounce on a held start button
      n0 = n_start_p;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
      chk("bounce_still_held", start_held, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
      chk("bounce_released", start_held, 1'b0);
      chk_int("bounce_pulses", n_start_p - n0, 1);

      // 6: stop held through a one-cycle reset
      s0 = n_stop_p;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      chk("rst_mid_stop_held", stop_held, 1'b0);
      edge_n = cyc + 1;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      chk_int("rst_mid_stop_pulses", n_stop_p - s0, 2);
      chk_int("rst_mid_latency", stop_p_cyc - edge_n, DB + 1);

      // Randomized segments with occasional resets
      for (int seg = 0; seg < 120; seg++) begin
         rlen = $urandom_range(1, 8);
         ra   = 1'($urandom_range(0, 1));
         rb   = ($urandom_range(0, 3) == 0) ? ra : 1'($urandom_range(0, 1));
         rr   = ($urandom_range(0, 29) == 0);
         for (int i = 0; i < rlen; i++) step(ra, rb, (i == 0) ? rr : 1'b0);
      end
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
      chk("final_start_held", start_held, 1'b0);
      chk("final_stop_held",  stop_held,  1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
